// File: rtl/rca_pkg.sv
// Shared types for blocks built around the 4-bit ripple-carry adder slice.
package rca_pkg;

  localparam int SLICE_W = 4;

  typedef logic [SLICE_W-1:0] slice_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca4.sv
// 4-bit ripple-carry adder slice: purely combinational, no internal registers.
module rca4
  import rca_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[SLICE_W];
  end

endmodule

// File: rtl/rca_wide_add_seq.sv
// Wide adder that time-multiplexes an external 4-bit RCA, one nibble per cycle, LSB first.
// Latency NSLICE cycles after acceptance; holds result in DONE until out_ready, single op in flight.
module rca_wide_add_seq
  import rca_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               op_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               carry_out,
  output logic [SLICE_W-1:0] add_a,
  output logic [SLICE_W-1:0] add_b,
  output logic               add_cin,
  input  logic [SLICE_W-1:0] add_sum,
  input  logic               add_cout
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
    $error("rca_wide_add_seq: WIDTH must be a positive multiple of 4");
  end

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operand slices are only presented to the RCA while running; idle/done drive zeros.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_q[idx*SLICE_W +: SLICE_W];
      add_b   = b_q[idx*SLICE_W +: SLICE_W];
      add_cin = carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= op_a;
            b_q   <= op_b;
            carry <= op_cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result[idx*SLICE_W +: SLICE_W] <= add_sum;
          carry <= add_cout;
          if (idx == LAST_IDX) begin
            carry_out <= add_cout;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
